rca_ft_reconfig_ctrl: RTL and testbench

RCA_FT_RECONFIG_CTRL -- requirements
Module: rca_ft_reconfig_ctrl

---
 rtl/rca_ft_reconfig_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_rca_ft_reconfig_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_ft_reconfig_ctrl.sv
// rca_ft_reconfig_ctrl
//
// Self-test and reconfiguration controller for a 4-bit ripple-carry adder
// built from five full-adder slices (slices 0..3 plus one spare, slice 4).
// A configuration f names the single slice that is bypassed. The controller
// tries f = 4, 3, 2, 1, 0 in turn. For each f it applies eight test vectors
// to the adder and compares the adder result with the expected sum. It locks
// the first f that passes every vector, or reports failure if none passes.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        single-cycle request to run self-test and reconfiguration
//   s_obs        adder sum output s[3:0]
//   cout_obs     adder carry output
//   bist_active  high while this block owns the adder operands
//   a_t, b_t     test operands driven to the adder
//   test         adder test-mode select (always 0)
//   is           operand shift selects is0..is5
//   cs           carry bypass selects CS0..CS4
//   ss           sum steering selects SS0..SS3
//   busy         high from CFG through the last CHECK
//   done         a passing configuration is locked
//   fail         no configuration passes
//   fault_idx    bypassed slice index held in the config register
module rca_ft_reconfig_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] s_obs,
  input  logic       cout_obs,
  output logic       bist_active,
  output logic [3:0] a_t,
  output logic [3:0] b_t,
  output logic       test,
  output logic [5:0] is,
  output logic [4:0] cs,
  output logic [3:0] ss,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [2:0] fault_idx
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_APPLY,
    ST_CHECK,
    ST_PASS,
    ST_FAIL
  } state_t;

  state_t     state;
  logic [2:0] f;
  logic [2:0] v;
  logic [4:0] exp_sum;
  logic       match;

  // Slices above the bypassed one take the next-lower operand bit.
  function automatic logic [5:0] dec_is(input logic [2:0] cfg);
    logic [5:0] r;
    r = '0;
    for (int j = 1; j <= 3; j++) begin
      if (3'(j) > cfg) begin
        r[2*j-2] = 1'b1;
        r[2*j-1] = 1'b1;
      end
    end
    return r;
  endfunction

  // Only the bypassed slice passes its carry-in straight through.
  function automatic logic [4:0] dec_cs(input logic [2:0] cfg);
    logic [4:0] r;
    r = '0;
    for (int k = 0; k <= 4; k++) begin
      r[k] = (3'(k) == cfg);
    end
    return r;
  endfunction

  // Sum bits at or above the bypassed slice are taken from the slice above.
  function automatic logic [3:0] dec_ss(input logic [2:0] cfg);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i <= 3; i++) begin
      r[i] = (3'(i) >= cfg);
    end
    return r;
  endfunction

  // Test vector ROM, returned as {a, b}.
  function automatic logic [7:0] vec_rom(input logic [2:0] idx);
    logic [7:0] r;
    case (idx)
      3'd0:    r = 8'h00;
      3'd1:    r = 8'hFF;
      3'd2:    r = 8'hF1;
      3'd3:    r = 8'hA5;
      3'd4:    r = 8'h5A;
      3'd5:    r = 8'h79;
      3'd6:    r = 8'h88;
      default: r = 8'h3C;
    endcase
    return r;
  endfunction

  assign test = 1'b0;

  // The operands are held through CHECK, so the expected result comes from
  // the registered operands.
  always_comb begin
    exp_sum = {1'b0, a_t} + {1'b0, b_t};
    match   = ({cout_obs, s_obs} == exp_sum);
  end

  // Sequencer. The outputs are registered here. done and fail are set on
  // the cycle after PASS or FAIL is entered. fault_idx is the config
  // register, and is/cs/ss are reloaded whenever it changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      f           <= 3'd4;
      v           <= 3'd0;
      a_t         <= 4'd0;
      b_t         <= 4'd0;
      bist_active <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fail        <= 1'b0;
      fault_idx   <= 3'd4;
      is          <= dec_is(3'd4);
      cs          <= dec_cs(3'd4);
      ss          <= dec_ss(3'd4);
    end else begin
      case (state)
        ST_IDLE, ST_PASS, ST_FAIL: begin
          if (state == ST_PASS) begin
            done <= 1'b1;
          end
          if (state == ST_FAIL) begin
            fail      <= 1'b1;
            fault_idx <= 3'd4;
            is        <= dec_is(3'd4);
            cs        <= dec_cs(3'd4);
            ss        <= dec_ss(3'd4);
          end
          // A new request restarts the search from the spare-slice config.
          if (start) begin
            state       <= ST_CFG;
            f           <= 3'd4;
            v           <= 3'd0;
            done        <= 1'b0;
            fail        <= 1'b0;
            bist_active <= 1'b1;
            busy        <= 1'b1;
          end
        end
        ST_CFG: begin
          fault_idx  <= f;
          is         <= dec_is(f);
          cs         <= dec_cs(f);
          ss         <= dec_ss(f);
          {a_t, b_t} <= vec_rom(v);
          state      <= ST_APPLY;
        end
        ST_APPLY: begin
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (match) begin
            if (v == 3'd7) begin
              state       <= ST_PASS;
              bist_active <= 1'b0;
              busy        <= 1'b0;
              a_t         <= 4'd0;
              b_t         <= 4'd0;
            end else begin
              v          <= v + 3'd1;
              {a_t, b_t} <= vec_rom(v + 3'd1);
              state      <= ST_APPLY;
            end
          end else begin
            a_t <= 4'd0;
            b_t <= 4'd0;
            if (f != 3'd0) begin
              f     <= f - 3'd1;
              v     <= 3'd0;
              state <= ST_CFG;
            end else begin
              state       <= ST_FAIL;
              bist_active <= 1'b0;
              busy        <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca_ft_reconfig_ctrl.sv
// tb_rca_ft_reconfig_ctrl
//
// Directed bench for rca_ft_reconfig_ctrl. A structural model of the
// five-slice adder, with selectable stuck-at faults, answers the
// controller's test operands. Its routing is driven by the controller's
// is/cs/ss outputs. The expected values are hand-computed constants.
module tb_rca_ft_reconfig_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] s_obs;
  logic       cout_obs;
  logic       bist_active;
  logic [3:0] a_t;
  logic [3:0] b_t;
  logic       test;
  logic [5:0] is;
  logic [4:0] cs;
  logic [3:0] ss;
  logic       busy;
  logic       done;
  logic       fail;
  logic [2:0] fault_idx;

  // 0 none, 1 slice 2 sum stuck-at-0, 2 slices 1 and 3 sum stuck-at-0,
  // 3 slice 0 carry stuck-at-1
  int         fault_mode;
  int         checks;
  int         errors;
  int         cycles;

  logic [4:0] sl_a;
  logic [4:0] sl_b;
  logic [4:0] sl_s;
  logic       carry;
  logic       gen;

  rca_ft_reconfig_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .s_obs      (s_obs),
    .cout_obs   (cout_obs),
    .bist_active(bist_active),
    .a_t        (a_t),
    .b_t        (b_t),
    .test       (test),
    .is         (is),
    .cs         (cs),
    .ss         (ss),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .fault_idx  (fault_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Five-slice adder. Slice k sees either operand bit k or bit k-1, and a
  // bypassed slice forwards its carry-in.
  always_comb begin
    sl_a  = '0;
    sl_b  = '0;
    sl_s  = '0;
    carry = 1'b0;
    gen   = 1'b0;
    sl_a[0] = a_t[0];
    sl_b[0] = b_t[0];
    sl_a[1] = is[0] ? a_t[0] : a_t[1];
    sl_b[1] = is[1] ? b_t[0] : b_t[1];
    sl_a[2] = is[2] ? a_t[1] : a_t[2];
    sl_b[2] = is[3] ? b_t[1] : b_t[2];
    sl_a[3] = is[4] ? a_t[2] : a_t[3];
    sl_b[3] = is[5] ? b_t[2] : b_t[3];
    sl_a[4] = a_t[3];
    sl_b[4] = b_t[3];
    for (int k = 0; k < 5; k++) begin
      sl_s[k] = sl_a[k] ^ sl_b[k] ^ carry;
      gen     = (sl_a[k] & sl_b[k]) | (carry & (sl_a[k] ^ sl_b[k]));
      if (fault_mode == 1 && k == 2) sl_s[k] = 1'b0;
      if (fault_mode == 2 && (k == 1 || k == 3)) sl_s[k] = 1'b0;
      if (fault_mode == 3 && k == 0) gen = 1'b1;
      carry = cs[k] ? carry : gen;
    end
    for (int i = 0; i < 4; i++) begin
      s_obs[i] = ss[i] ? sl_s[i+1] : sl_s[i];
    end
    cout_obs = carry;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkConfig(input string tag, input logic [2:0] fi,
                             input logic [5:0] e_is, input logic [4:0] e_cs,
                             input logic [3:0] e_ss);
    checkOutput({tag, "_fault_idx"}, 32'(fault_idx), 32'(fi));
    checkOutput({tag, "_is"}, 32'(is), 32'(e_is));
    checkOutput({tag, "_cs"}, 32'(cs), 32'(e_cs));
    checkOutput({tag, "_ss"}, 32'(ss), 32'(e_ss));
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle start pulse; returns just after the edge that samples it.
  task automatic applyStimulus();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic runUntilFinished(output int n);
    n = 0;
    while (!(done || fail) && n < 200) begin
      waitEdges(1);
      n++;
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    fault_mode = 0;
    rst        = 1'b1;
    start      = 1'b0;
    waitEdges(2);

    // Reset values
    checkConfig("rst", 3'd4, 6'b000000, 5'b10000, 4'b0000);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_bist", 32'(bist_active), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_fail", 32'(fail), 32'd0);
    checkOutput("rst_ops", 32'({a_t, b_t}), 32'h00);
    checkOutput("rst_test", 32'(test), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Fault-free run with exact latency
    applyStimulus();
    checkOutput("ff_cfg_busy", 32'(busy), 32'd1);
    checkOutput("ff_cfg_bist", 32'(bist_active), 32'd1);
    waitEdges(1);
    checkOutput("ff_vec0", 32'({a_t, b_t}), 32'h00);
    waitEdges(2);
    checkOutput("ff_vec1", 32'({a_t, b_t}), 32'hFF);
    waitEdges(14);
    checkOutput("ff_done_n17", 32'(done), 32'd0);
    checkOutput("ff_busy_n17", 32'(busy), 32'd0);
    waitEdges(1);
    checkOutput("ff_done_n18", 32'(done), 32'd1);
    checkOutput("ff_fail", 32'(fail), 32'd0);
    checkOutput("ff_ops_idle", 32'({a_t, b_t}), 32'h00);
    checkConfig("ff", 3'd4, 6'b000000, 5'b10000, 4'b0000);
    waitEdges(3);
    checkOutput("ff_done_persist", 32'(done), 32'd1);

    // Slice 2 sum stuck-at-0: f=4 and f=3 fail at vector 1, f=2 passes
    fault_mode = 1;
    applyStimulus();
    checkOutput("s2_done_cleared", 32'(done), 32'd0);
    runUntilFinished(cycles);
    checkOutput("s2_latency", 32'(cycles), 32'd28);
    checkOutput("s2_done", 32'(done), 32'd1);
    checkOutput("s2_fail", 32'(fail), 32'd0);
    checkConfig("s2", 3'd2, 6'b110000, 5'b00100, 4'b1100);

    // Slices 1 and 3 faulty: every configuration fails at vector 1
    fault_mode = 2;
    applyStimulus();
    runUntilFinished(cycles);
    checkOutput("s13_latency", 32'(cycles), 32'd26);
    checkOutput("s13_fail", 32'(fail), 32'd1);
    checkOutput("s13_done", 32'(done), 32'd0);
    checkOutput("s13_bist", 32'(bist_active), 32'd0);
    checkConfig("s13", 3'd4, 6'b000000, 5'b10000, 4'b0000);
    waitEdges(2);
    checkOutput("s13_fail_persist", 32'(fail), 32'd1);

    // start held high for every busy cycle: a single run with unchanged timing
    fault_mode = 0;
    @(negedge clk);
    start = 1'b1;
    waitEdges(1);
    checkOutput("hold_fail_cleared", 32'(fail), 32'd0);
    waitEdges(16);
    start = 1'b0;
    waitEdges(1);
    checkOutput("hold_done_n17", 32'(done), 32'd0);
    waitEdges(1);
    checkOutput("hold_done_n18", 32'(done), 32'd1);
    checkConfig("hold", 3'd4, 6'b000000, 5'b10000, 4'b0000);

    // Slice 0 carry stuck-at-1: f=4..1 fail at vector 0, f=0 passes
    fault_mode = 3;
    applyStimulus();
    runUntilFinished(cycles);
    checkOutput("c0_latency", 32'(cycles), 32'd30);
    checkOutput("c0_done", 32'(done), 32'd1);
    checkConfig("c0", 3'd0, 6'b111111, 5'b00001, 4'b1111);

    // Reset during APPLY of f=3 aborts the run without waiting for a clock
    fault_mode = 1;
    applyStimulus();
    waitEdges(6);
    checkOutput("rstmid_pre_fi", 32'(fault_idx), 32'd3);
    checkOutput("rstmid_pre_bist", 32'(bist_active), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    checkConfig("rstmid", 3'd4, 6'b000000, 5'b10000, 4'b0000);
    checkOutput("rstmid_busy", 32'(busy), 32'd0);
    checkOutput("rstmid_bist", 32'(bist_active), 32'd0);
    checkOutput("rstmid_ops", 32'({a_t, b_t}), 32'h00);
    checkOutput("rstmid_done", 32'(done), 32'd0);
    @(negedge clk);
    rst        = 1'b0;
    fault_mode = 0;
    applyStimulus();
    checkOutput("restart_busy", 32'(busy), 32'd1);
    waitEdges(1);
    checkOutput("restart_fi", 32'(fault_idx), 32'd4);
    runUntilFinished(cycles);
    checkOutput("restart_done", 32'(done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
